// File: rtl/dq_reg_array_if.sv
// Port bundle for dq_reg_array: write port, registered read port and bulk-clear control.
// Requests are single-cycle with no handshake back-pressure; busy is the only stall indication.
interface dq_reg_array_if #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 4
) ();

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_valid;
  logic              rd_hit;
  logic              clr_req;
  logic              busy;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, clr_req,
    input  rd_data, rd_valid, rd_hit, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, clr_req,
    output rd_data, rd_valid, rd_hit, busy
  );

endinterface

// File: rtl/dq_reg_array.sv
// DEPTH x WIDTH register array with per-word valid bits, a write-first registered read
// port and a one-word-per-cycle bulk invalidate sequencer.
module dq_reg_array #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  dq_reg_array_if.slave    bus,
  output logic             o_dbg_state
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic [DEPTH-1:0]  r_valid;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [WIDTH-1:0]  r_rd_data;
  logic              r_rd_valid;
  logic              r_rd_hit;

  logic              w_accept;
  logic              w_wr_go;
  logic              w_rd_go;
  logic              w_bypass;
  logic              w_clr_last;

  // Port handshake: wr_en/rd_en/clr_req are sampled once per rising edge. A read or
  // write is accepted only in IDLE with clr_req low; dropped requests are not queued.
  assign w_clr_last = (r_clr_ptr == ADDR_W'(DEPTH - 1));

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.clr_req) begin
          w_next_state = S_CLEAR;
        end else begin
          w_accept = 1'b1;
        end
      end
      S_CLEAR: begin
        if (w_clr_last) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_wr_go  = w_accept & bus.wr_en;
  assign w_rd_go  = w_accept & bus.rd_en;
  assign w_bypass = w_wr_go & (bus.wr_addr == bus.rd_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Pointer wraps to zero naturally after the last word, ready for the next clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_ptr <= '0;
    end else if (r_state == S_CLEAR) begin
      r_clr_ptr <= r_clr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (r_state == S_CLEAR) begin
      r_valid[r_clr_ptr] <= 1'b0;
    end else if (w_wr_go) begin
      r_valid[bus.wr_addr] <= 1'b1;
    end
  end

  // Word storage carries no reset; the valid bits alone decide what is observable.
  always_ff @(posedge clk) begin
    if (w_wr_go) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_hit   <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd_go;
      if (w_rd_go) begin
        if (w_bypass) begin
          r_rd_hit  <= 1'b1;
          r_rd_data <= bus.wr_data;
        end else begin
          r_rd_hit  <= r_valid[bus.rd_addr];
          r_rd_data <= r_valid[bus.rd_addr] ? r_mem[bus.rd_addr] : '0;
        end
      end
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_hit   = r_rd_hit;
  assign bus.busy     = (r_state == S_CLEAR);
  assign o_dbg_state  = r_state;

endmodule

// File: doc/dq_reg_array.md
Name: dq_reg_array

Overview:
- Parametrised, clocked successor to the 4-bit DQ latch array.
- Stores DEPTH words of WIDTH bits, with one write port and one registered read port.
- Each word has a valid bit. A bulk-clear state machine invalidates the whole array one word per cycle.
- Used as the general storage cell array for register files and small buffers in the memory-bitcell hierarchy.

Parameters:
- WIDTH, 4, bits per word.
- ADDR_W, 4, address width. DEPTH = 2**ADDR_W words (default 16).

Ports:
- clk  input  1  clock. All state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- wr_en  input  1  write request this cycle.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  WIDTH  write data.
- rd_en  input  1  read request this cycle.
- rd_addr  input  ADDR_W  read address.
- rd_data  output  WIDTH  read data, registered.
- rd_valid  output  1  rd_data/rd_hit updated by a read accepted the previous cycle.
- rd_hit  output  1  the word read was valid.
- clr_req  input  1  request bulk invalidate.
- busy  output  1  clear in progress; ports blocked.

Behaviour:
- Reset (rst_n=0, async):
  - all valid bits = 0; rd_data = 0; rd_valid = 0; rd_hit = 0; busy = 0.
  - FSM = IDLE; clear pointer = 0.
  - Word storage is not reset.
- FSM has two states: IDLE and CLEAR.
  - IDLE -> CLEAR on clr_req=1. busy=1 from the next cycle.
  - In CLEAR, one valid bit is cleared per cycle, at the clear pointer, starting at 0. The pointer increments by 1 per cycle.
  - After clearing word DEPTH-1: pointer wraps to 0, FSM -> IDLE, busy=0 the following cycle.
  - A clear therefore holds busy high for exactly DEPTH cycles.
  - clr_req while in CLEAR is ignored; it does not restart or extend the clear.
- Write, in IDLE with wr_en=1:
  - mem[wr_addr] <= wr_data; valid[wr_addr] <= 1 at the rising edge.
  - The new value is readable by a read issued in the next cycle.
- Read:
  - rd_en=1 in cycle t (IDLE) gives rd_valid=1 in cycle t+1, with:
    - rd_hit = valid[rd_addr];
    - rd_data = mem[rd_addr] if valid, else all zeros.
  - Latency is 1 cycle.
  - When rd_en=0 (or a read is blocked), rd_valid=0 next cycle; rd_data and rd_hit hold their last values.
- Bypass: wr_en and rd_en in the same cycle with wr_addr == rd_addr gives rd_data = wr_data and rd_hit = 1 next cycle (write-first).
- Same cycle, different addresses: both complete independently.
- clr_req with wr_en or rd_en in the same IDLE cycle:
  - clear takes priority; the write and the read are dropped;
  - rd_valid = 0 next cycle; storage is unchanged.
- While busy=1: wr_en and rd_en are ignored, with no storage or valid change and rd_valid=0. The requester must retry after busy falls.
- Reset mid-clear: the FSM returns to IDLE immediately; valid bits are all 0 regardless of clear progress.
- Addresses cover the full 2**ADDR_W range; there are no out-of-range addresses.

Test Plan (WIDTH=4, ADDR_W=4):
- Reset then read: rst_n low 2 cycles, then rd_en with rd_addr=5 -> next cycle rd_valid=1, rd_hit=0, rd_data=0000.
- Write/read: write addr 3 = 1010, next cycle read addr 3 -> rd_valid=1, rd_hit=1, rd_data=1010. Repeat the pattern over all 16 addresses with data = addr.
- Bypass: wr_en addr 7 = 0110 and rd_en addr 7 in the same cycle -> next cycle rd_data=0110, rd_hit=1. Repeat with rd_addr=8 (unwritten) -> rd_hit=0, rd_data=0000.
- Bulk clear: fill all 16 words, pulse clr_req -> busy high for exactly 16 cycles.
  - A write to addr 2 and a read issued mid-clear are ignored (rd_valid=0).
  - After busy falls, reads of every address give rd_hit=0, rd_data=0000.
- Priority: clr_req, wr_en (addr 1 = 1111) and rd_en in the same cycle -> write dropped and rd_valid=0 next cycle. After the clear, read addr 1 -> rd_hit=0.
- Reset mid-clear: assert rst_n=0 at clear cycle 6 -> busy=0 immediately. After release, a read of addr 10 gives rd_hit=0, and a new write/read works normally.
